scc_mem_arbiter: RTL and testbench

Parametrised memory front end for the scc core family: arbitrates NUM_CH requestor channels (channel 0 = instruction fetch, channels 1..NUM_CH-1 = data ports) onto one single-ported instruction/data memory with configurable read latency. It replaces the fixed one-fetch-port/one-data-port memory hookup in the scc top level. It adds valid/ready handshakes, round-robin arbitration, wait-state handling, halt draining and sticky error reporting.

---
 rtl/scc_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_scc_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_mem_arbiter.sv
// Round-robin front end that shares one single-ported instruction/data memory
// among NUM_CH requestors (channel 0 = fetch), with wait states, halt drain and sticky errors.
module scc_mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     halt,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_re,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     halt_f,
  output logic [1:0]               err_bits
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e            state_q;
  logic [CH_W-1:0]   last_grant_q;
  logic [CH_W-1:0]   ch_q;
  logic              write_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [NUM_CH-1:0] rsp_valid_q;
  logic              halt_seen_q;
  logic [1:0]        err_q;

  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [NUM_CH-1:0] grant_oh;
  logic              can_grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic [NUM_CH-1:0] ch_oh;

  // Handshake: a request transfers on an enabled edge where req_valid[i] and
  // req_ready[i] are both high; a requestor must hold valid and its
  // write/addr/wdata stable until that edge. At most one ready bit is high.
  always_comb begin : p_arb
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_CH;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  assign can_grant = (state_q == IDLE) && !halt_seen_q && clk_en && grant_found;
  assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_write = req_write[grant_idx];

  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
    ch_oh               = '0;
    ch_oh[ch_q]         = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      ch_q         <= '0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_valid_q  <= '0;
      halt_seen_q  <= 1'b0;
      err_q        <= '0;
    end else if (clk_en) begin
      rsp_valid_q <= '0;
      if (halt) halt_seen_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (can_grant) begin
            last_grant_q <= grant_idx;
            ch_q         <= grant_idx;
            write_q      <= sel_write;
            if (sel_addr[1:0] != 2'b00) begin
              // Misaligned: answer immediately with zero data and never touch memory.
              err_q[0]    <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_valid_q <= grant_oh;
              state_q     <= RESP;
            end else begin
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
              state_q     <= ACCESS;
            end
          end else if (halt_seen_q && (req_valid != '0)) begin
            err_q[1] <= 1'b1;
          end
        end
        ACCESS: begin
          if (write_q) begin
            rsp_rdata_q <= '0;
            rsp_valid_q <= ch_oh;
            state_q     <= RESP;
          end else begin
            cnt_q   <= CNT_W'(MEM_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            rsp_rdata_q <= mem_rdata;
            rsp_valid_q <= ch_oh;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = can_grant ? grant_oh : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = (state_q == ACCESS) && !write_q && clk_en;
  assign mem_we    = (state_q == ACCESS) && write_q && clk_en;
  assign halt_f    = halt_seen_q && (state_q == IDLE);
  assign err_bits  = err_q;

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Bench for scc_mem_arbiter: responses are predicted (channel, data, cycle) when a
// request is accepted and compared by a monitor when rsp_valid fires.
module tb_scc_mem_arbiter;
  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;
  localparam int EW      = 16 + NUM_CH + DATA_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     clk_en;
  logic                     halt;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_re;
  logic                     mem_we;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     halt_f;
  logic [1:0]               err_bits;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_exp  = 0;
  int n_rsp  = 0;
  int n_strobe = 0;
  int lg     = NUM_CH - 1;
  logic [EW-1:0]     exp_q[$];
  logic [EW-1:0]     mon_e;
  logic [DATA_W-1:0] mem_arr [0:63];
  logic [DATA_W-1:0] rd_pipe [0:MEM_LAT-1];

  scc_mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .halt_f(halt_f), .err_bits(err_bits)
  );

  // ---- clock / reset / memory model ----
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] <= '0;
    end else if (clk_en) begin
      rd_pipe[0] <= mem_re ? mem_arr[mem_addr[7:2]] : rd_pipe[0];
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_CH-1:0] v, input int last);
    for (int k = 1; k <= NUM_CH; k++)
      if (v[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    return -1;
  endfunction

  // ---- scoreboard monitor ----
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (mem_re || mem_we) n_strobe++;
      if (rsp_valid != '0 && clk_en) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp", 64'({16'(cyc), rsp_valid, rsp_rdata}), 64'(mon_e));
        end
      end
    end
  end

  // ---- driver tasks ----
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lg  = NUM_CH - 1;
  endtask

  task automatic check_reset_state(input string tag);
    #2;
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_strobes"},   64'({mem_re, mem_we}), 64'd0);
    check({tag, "_halt_f"},    64'(halt_f),    64'd0);
    check({tag, "_err_bits"},  64'(err_bits),  64'd0);
  endtask

  // Drive one request on ch, wait for its accept, predict the response, then drop valid.
  // Returns at the negedge of the cycle after the accept.
  task automatic issue(input int ch, input bit wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input int extra, output int acc);
    int n;
    int lat;
    logic [DATA_W-1:0] d;
    logic [NUM_CH-1:0] oh;
    n = 0;
    @(negedge clk);
    req_valid[ch] = 1'b1;
    req_write[ch] = wr;
    req_addr[ch*ADDR_W +: ADDR_W]  = addr;
    req_wdata[ch*DATA_W +: DATA_W] = wdata;
    #1;
    while (req_ready[ch] !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    acc = cyc;
    check("accept", 64'(req_ready), 64'(1 << ch));
    if (req_ready[ch] === 1'b1) begin
      if (addr[1:0] != 2'b00) begin lat = 1; d = '0; end
      else if (wr) begin lat = 2; d = '0; end
      else begin lat = 2 + MEM_LAT; d = mem_arr[addr[7:2]]; end
      oh = '0;
      oh[ch] = 1'b1;
      exp_q.push_back({16'(acc + lat + extra), oh, d});
      n_exp++;
      lg = ch;
    end
    @(negedge clk);
    req_valid[ch] = 1'b0;
  endtask

  // Hold reads on every channel in mask until n_grants have been accepted.
  task automatic rr_burst(input logic [NUM_CH-1:0] mask, input int n_grants);
    int got;
    int prev;
    int to;
    int w;
    logic [NUM_CH-1:0] oh;
    got = 0; prev = 0; to = 0;
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      req_write[c] = 1'b0;
      req_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(32'h80 + c * 4);
    end
    req_valid = mask;
    while (got < n_grants && to < 200) begin
      #1;
      if (req_ready != '0) begin
        w  = rr_pick(mask, lg);
        oh = '0;
        oh[w] = 1'b1;
        check("rr_grant", 64'(req_ready), 64'(oh));
        if (got > 0) check("rr_gap", 64'(cyc - prev), 64'(3 + MEM_LAT));
        exp_q.push_back({16'(cyc + 2 + MEM_LAT), oh, mem_arr[32 + w]});
        n_exp++;
        lg   = w;
        prev = cyc;
        got++;
      end
      @(negedge clk);
      to++;
    end
    check("rr_done", 64'(got), 64'(n_grants));
    req_valid = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---- test sequence ----
  initial begin
    int acc;
    int s0;
    rst = 1'b1; clk_en = 1'b1; halt = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom_range(32'h7fff_ffff, 1);
    mem_arr[4] = 32'hDEAD_BEEF;

    do_reset();
    check_reset_state("rst0");

    // Single read from fetch channel.
    issue(0, 1'b0, 32'h10, '0, 0, acc);
    #2;
    check("rd_mem_re", 64'({mem_re, mem_we}), 64'b10);
    check("rd_mem_addr", 64'(mem_addr), 64'h10);
    @(negedge clk);
    #2;
    check("rd_mem_re_once", 64'(mem_re), 64'd0);
    drain();

    // Contention: two channels, then all three.
    rr_burst(3'b011, 4);
    drain();
    rr_burst(3'b111, 3);
    drain();

    // Write.
    issue(1, 1'b1, 32'h20, 32'hCAFE_0001, 0, acc);
    #2;
    check("wr_strobes", 64'({mem_re, mem_we}), 64'b01);
    check("wr_mem_addr", 64'(mem_addr), 64'h20);
    check("wr_mem_wdata", 64'(mem_wdata), 64'hCAFE_0001);
    drain();

    // Misaligned read.
    s0 = n_strobe;
    issue(1, 1'b0, 32'h22, '0, 0, acc);
    #2;
    check("mis_err", 64'(err_bits), 64'b01);
    drain();
    check("mis_no_strobe", 64'(n_strobe), 64'(s0));

    // clk_en low for 3 cycles during WAIT.
    issue(0, 1'b0, 32'h14, '0, 3, acc);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    clk_en = 1'b1;
    drain();

    // clk_en low for 2 cycles in ACCESS: strobe suppressed then issued once.
    issue(2, 1'b1, 32'h30, 32'h1234_5678, 2, acc);
    clk_en = 1'b0;
    #2;
    check("stall_we_off0", 64'(mem_we), 64'd0);
    @(negedge clk);
    #2;
    check("stall_we_off1", 64'(mem_we), 64'd0);
    @(negedge clk);
    clk_en = 1'b1;
    #2;
    check("stall_we_on", 64'(mem_we), 64'd1);
    check("stall_wdata", 64'(mem_wdata), 64'h1234_5678);
    drain();
    check("err_sticky", 64'(err_bits), 64'b01);

    do_reset();
    check_reset_state("rst1");

    // Halt pulse while a read is in flight, then a request while halted.
    issue(0, 1'b0, 32'h40, '0, 0, acc);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    #2;
    check("halt_f_busy", 64'(halt_f), 64'd0);
    repeat (3) @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0 +: ADDR_W] = 32'h44;
    #2;
    check("halt_f_idle", 64'(halt_f), 64'd1);
    check("halt_no_ready0", 64'(req_ready), 64'd0);
    @(negedge clk);
    #2;
    check("halt_no_ready1", 64'(req_ready), 64'd0);
    check("halt_err", 64'(err_bits), 64'b10);
    req_valid = '0;
    check("halt_drained", 64'(exp_q.size()), 64'd0);

    do_reset();
    check_reset_state("rst2");

    // Reset while a read waits on memory: the response is dropped.
    issue(2, 1'b0, 32'h48, '0, 0, acc);
    @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    n_exp--;
    @(negedge clk);
    rst = 1'b0;
    lg  = NUM_CH - 1;
    check_reset_state("midrst");
    repeat (6) @(negedge clk);

    // After reset channel 0 has priority.
    rr_burst(3'b111, 3);
    drain();
    repeat (2) @(negedge clk);
    check("rsp_count", 64'(n_rsp), 64'(n_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
